id_stage: RTL and testbench

- Decode stage directly downstream of the fetch stage. It consumes the IF/ID register pair (instruction, pc+4).
- Decodes a MIPS-I integer subset and reads the 32x32 register file. It accepts the writeback port from WB.
- Resolves beq/bne/j in ID and detects load-use and branch-operand hazards.
- Drives the fetch-control signals (stall, flush_if, jump_taken, branch_taken, pc_jump, pc_branch) and registers the ID/EX pipeline bundle consumed by EX.

---
 rtl/id_stage_pkg.sv | 154 +++++++++++++++
 rtl/id_stage_regfile.sv | 45 ++++
 rtl/id_stage.sv | 180 ++++++++++++++++++
 tb/tb_id_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode constants, ALU encodings and the ID/EX bundle for id_stage.
package id_stage_pkg;

    localparam int unsigned NumRegs  = 32;
    localparam int unsigned RegAddrW = 5;
    localparam int unsigned AluOpW   = 4;

    localparam logic [31:0] NopWord = 32'h0000_0000;

    // Primary opcodes
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [AluOpW-1:0] {
        AluAdd = 4'd0,
        AluSub = 4'd1,
        AluAnd = 4'd2,
        AluOr  = 4'd3,
        AluSlt = 4'd4,
        AluSll = 4'd5,
        AluLui = 4'd6
    } alu_op_e;

    // Registered bundle handed to EX
    typedef struct packed {
        logic [31:0]         pc_next;
        logic [31:0]         rs_data;
        logic [31:0]         rt_data;
        logic [31:0]         imm;
        logic [RegAddrW-1:0] rs;
        logic [RegAddrW-1:0] rt;
        logic [RegAddrW-1:0] dst;
        alu_op_e             alu_op;
        logic                alu_src;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
    } id_ex_t;

    // Decoded control for the instruction sitting in IF/ID
    typedef struct packed {
        logic    valid;
        logic    is_rtype;
        logic    is_beq;
        logic    is_bne;
        logic    is_j;
        logic    uses_rs;
        logic    uses_rt;
        logic    zero_ext;
        logic    is_lui;
        alu_op_e alu_op;
        logic    alu_src;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
    } ctrl_t;

    // Anything unrecognised (and the nop word) comes back all-zero, i.e. a bubble.
    function automatic ctrl_t decode(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        unique case (instr[31:26])
            OpRtype: begin
                c.valid     = 1'b1;
                c.is_rtype  = 1'b1;
                c.uses_rs   = 1'b1;
                c.uses_rt   = 1'b1;
                c.reg_write = 1'b1;
                unique case (instr[5:0])
                    FnAdd:   c.alu_op = AluAdd;
                    FnSub:   c.alu_op = AluSub;
                    FnAnd:   c.alu_op = AluAnd;
                    FnOr:    c.alu_op = AluOr;
                    FnSlt:   c.alu_op = AluSlt;
                    FnSll:   c.alu_op = AluSll;
                    default: c = '0;
                endcase
            end
            OpAddi, OpSlti, OpAndi, OpOri: begin
                c.valid     = 1'b1;
                c.uses_rs   = 1'b1;
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.zero_ext  = (instr[31:26] == OpAndi) || (instr[31:26] == OpOri);
                unique case (instr[31:26])
                    OpSlti:  c.alu_op = AluSlt;
                    OpAndi:  c.alu_op = AluAnd;
                    OpOri:   c.alu_op = AluOr;
                    default: c.alu_op = AluAdd;
                endcase
            end
            OpLui: begin
                c.valid     = 1'b1;
                c.is_lui    = 1'b1;
                c.zero_ext  = 1'b1;
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = AluLui;
            end
            OpLw: begin
                c.valid      = 1'b1;
                c.uses_rs    = 1'b1;
                c.alu_src    = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            OpSw: begin
                c.valid     = 1'b1;
                c.uses_rs   = 1'b1;
                c.uses_rt   = 1'b1;
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OpBeq, OpBne: begin
                c.valid   = 1'b1;
                c.is_beq  = (instr[31:26] == OpBeq);
                c.is_bne  = (instr[31:26] == OpBne);
                c.uses_rs = 1'b1;
                c.uses_rt = 1'b1;
            end
            OpJ: begin
                c.valid = 1'b1;
                c.is_j  = 1'b1;
            end
            default: c = '0;
        endcase
        // sll r0,r0,0 is the canonical nop and must not raise any control
        if (instr == NopWord) begin
            c = '0;
        end
        return c;
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two async read ports, one sync write port,
// write-through bypass on reads, r0 hardwired to zero.
module id_stage_regfile
    import id_stage_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [RegAddrW-1:0] waddr_i,
    input  logic [31:0]         wdata_i,
    input  logic [RegAddrW-1:0] raddr_a_i,
    output logic [31:0]         rdata_a_o,
    input  logic [RegAddrW-1:0] raddr_b_i,
    output logic [31:0]         rdata_b_o
);

    logic [31:0] mem_q [NumRegs];
    logic        wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    // Storage: cleared on reset, writes to r0 dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegs; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports with same-cycle writeback bypass
    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        if (raddr_a_i != '0) begin
            rdata_a_o = (wr_en && (waddr_i == raddr_a_i)) ? wdata_i : mem_q[raddr_a_i];
        end
        if (raddr_b_i != '0) begin
            rdata_b_o = (wr_en && (waddr_i == raddr_b_i)) ? wdata_i : mem_q[raddr_b_i];
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS-I decode stage: decode, register read, ID-resolved beq/bne/j,
// load-use and branch-operand hazard detection, ID/EX pipeline register.
// Optional build macro ID_STALL_CNT_EN adds stall_cycles / redirect_count counters.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_OP_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           if_id_instruction,
    input  logic [31:0]           if_id_pc_next,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [31:0]           wb_data,
    input  logic                  ex_mem_reg_write,
    input  logic                  ex_mem_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic [31:0]           ex_mem_alu_result,
`ifdef ID_STALL_CNT_EN
    output logic [31:0]           stall_cycles,
    output logic [31:0]           redirect_count,
`endif
    output logic                  stall,
    output logic                  flush_if,
    output logic                  jump_taken,
    output logic                  branch_taken,
    output logic [31:0]           pc_jump,
    output logic [31:0]           pc_branch,
    output logic [31:0]           id_ex_pc_next,
    output logic [31:0]           id_ex_rs_data,
    output logic [31:0]           id_ex_rt_data,
    output logic [31:0]           id_ex_imm,
    output logic [REG_ADDR_W-1:0] id_ex_rs,
    output logic [REG_ADDR_W-1:0] id_ex_rt,
    output logic [REG_ADDR_W-1:0] id_ex_dst,
    output logic [ALU_OP_W-1:0]   id_ex_alu_op,
    output logic                  id_ex_alu_src,
    output logic                  id_ex_reg_write,
    output logic                  id_ex_mem_read,
    output logic                  id_ex_mem_write,
    output logic                  id_ex_mem_to_reg
);

    ctrl_t         ctrl;
    id_ex_t        id_ex_d, id_ex_q;
    logic [4:0]    rs_idx, rt_idx, rd_idx;
    logic [15:0]   imm16;
    logic [31:0]   imm_ext;
    logic [31:0]   rs_data, rt_data;
    logic [31:0]   cmp_a, cmp_b;
    logic          is_branch, load_use, branch_hazard, branch_cond;

    assign rs_idx = if_id_instruction[25:21];
    assign rt_idx = if_id_instruction[20:16];
    assign rd_idx = if_id_instruction[15:11];
    assign imm16  = if_id_instruction[15:0];

    id_stage_regfile u_regfile (
        .clk_i     (clk),
        .rst_i     (rst),
        .we_i      (wb_reg_write),
        .waddr_i   (wb_rd),
        .wdata_i   (wb_data),
        .raddr_a_i (rs_idx),
        .rdata_a_o (rs_data),
        .raddr_b_i (rt_idx),
        .rdata_b_o (rt_data)
    );

    // Decode, immediate extension and target computation
    always_comb begin
        ctrl      = decode(if_id_instruction);
        is_branch = ctrl.is_beq | ctrl.is_bne;
        if (ctrl.is_lui) begin
            imm_ext = {imm16, 16'h0000};
        end else if (ctrl.zero_ext) begin
            imm_ext = {16'h0000, imm16};
        end else begin
            imm_ext = {{16{imm16[15]}}, imm16};
        end
        pc_branch = if_id_pc_next + {{14{imm16[15]}}, imm16, 2'b00};
        pc_jump   = {if_id_pc_next[31:28], if_id_instruction[25:0], 2'b00};
    end

    // Hazards, branch operand forwarding and redirect outputs
    always_comb begin
        load_use = id_ex_q.mem_read && (id_ex_q.dst != '0) &&
                   ((ctrl.uses_rs && (rs_idx == id_ex_q.dst)) ||
                    (ctrl.uses_rt && (rt_idx == id_ex_q.dst)));

        // Operand still being produced in EX, or a load sitting in MEM
        branch_hazard = is_branch && (
            (id_ex_q.reg_write &&
             (((rs_idx != '0) && (rs_idx == id_ex_q.dst)) ||
              ((rt_idx != '0) && (rt_idx == id_ex_q.dst)))) ||
            (ex_mem_mem_read &&
             (((rs_idx != '0) && (rs_idx == ex_mem_rd)) ||
              ((rt_idx != '0) && (rt_idx == ex_mem_rd)))));

        stall = load_use | branch_hazard;

        cmp_a = (ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == rs_idx)) ?
                ex_mem_alu_result : rs_data;
        cmp_b = (ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == rt_idx)) ?
                ex_mem_alu_result : rt_data;

        branch_cond  = (cmp_a == cmp_b) ^ ctrl.is_bne;
        branch_taken = !stall && is_branch && branch_cond;
        jump_taken   = !stall && ctrl.is_j;
        flush_if     = jump_taken | branch_taken;
    end

    // Next ID/EX contents: bubble on stall, redirect or non-issuing instruction
    always_comb begin
        id_ex_d = '0;
        if (!stall && !flush_if && ctrl.valid) begin
            id_ex_d.pc_next    = if_id_pc_next;
            id_ex_d.rs_data    = rs_data;
            id_ex_d.rt_data    = rt_data;
            id_ex_d.imm        = imm_ext;
            id_ex_d.rs         = rs_idx;
            id_ex_d.rt         = rt_idx;
            id_ex_d.dst        = ctrl.is_rtype ? rd_idx : rt_idx;
            id_ex_d.alu_op     = ctrl.alu_op;
            id_ex_d.alu_src    = ctrl.alu_src;
            id_ex_d.reg_write  = ctrl.reg_write;
            id_ex_d.mem_read   = ctrl.mem_read;
            id_ex_d.mem_write  = ctrl.mem_write;
            id_ex_d.mem_to_reg = ctrl.mem_to_reg;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign id_ex_pc_next    = id_ex_q.pc_next;
    assign id_ex_rs_data    = id_ex_q.rs_data;
    assign id_ex_rt_data    = id_ex_q.rt_data;
    assign id_ex_imm        = id_ex_q.imm;
    assign id_ex_rs         = id_ex_q.rs;
    assign id_ex_rt         = id_ex_q.rt;
    assign id_ex_dst        = id_ex_q.dst;
    assign id_ex_alu_op     = id_ex_q.alu_op;
    assign id_ex_alu_src    = id_ex_q.alu_src;
    assign id_ex_reg_write  = id_ex_q.reg_write;
    assign id_ex_mem_read   = id_ex_q.mem_read;
    assign id_ex_mem_write  = id_ex_q.mem_write;
    assign id_ex_mem_to_reg = id_ex_q.mem_to_reg;

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q, redirect_cnt_q;

    // Free-running event counters, wrapping at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_if) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles   = stall_cnt_q;
    assign redirect_count = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Table-driven bench for id_stage with a scoreboard queue for the ID/EX bundle.
module tb_id_stage;
    import id_stage_pkg::*;

    typedef struct packed {
        logic [31:0] pc_next;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } idx_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        em_we;
        logic        em_mr;
        logic [4:0]  em_rd;
        logic [31:0] em_res;
        logic [3:0]  comb;   // {stall, flush_if, jump_taken, branch_taken}
        idx_t        idx;
    } vec_t;

    localparam int NVec = 20;

    logic        clk, rst;
    logic [31:0] if_id_instruction, if_id_pc_next;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_mem_reg_write, ex_mem_mem_read;
    logic [4:0]  ex_mem_rd;
    logic [31:0] ex_mem_alu_result;
    logic        stall, flush_if, jump_taken, branch_taken;
    logic [31:0] pc_jump, pc_branch;
    logic [31:0] id_ex_pc_next, id_ex_rs_data, id_ex_rt_data, id_ex_imm;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dst;
    logic [3:0]  id_ex_alu_op;
    logic        id_ex_alu_src, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
    logic        id_ex_mem_to_reg;
`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cycles, redirect_count;
`endif

    vec_t tbl [NVec];
    idx_t sb_q [$];
    int   n_cmp = 0;
    int   n_err = 0;

    id_stage dut (
        .clk               (clk),
        .rst               (rst),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_next     (if_id_pc_next),
        .wb_reg_write      (wb_reg_write),
        .wb_rd             (wb_rd),
        .wb_data           (wb_data),
        .ex_mem_reg_write  (ex_mem_reg_write),
        .ex_mem_mem_read   (ex_mem_mem_read),
        .ex_mem_rd         (ex_mem_rd),
        .ex_mem_alu_result (ex_mem_alu_result),
`ifdef ID_STALL_CNT_EN
        .stall_cycles      (stall_cycles),
        .redirect_count    (redirect_count),
`endif
        .stall             (stall),
        .flush_if          (flush_if),
        .jump_taken        (jump_taken),
        .branch_taken      (branch_taken),
        .pc_jump           (pc_jump),
        .pc_branch         (pc_branch),
        .id_ex_pc_next     (id_ex_pc_next),
        .id_ex_rs_data     (id_ex_rs_data),
        .id_ex_rt_data     (id_ex_rt_data),
        .id_ex_imm         (id_ex_imm),
        .id_ex_rs          (id_ex_rs),
        .id_ex_rt          (id_ex_rt),
        .id_ex_dst         (id_ex_dst),
        .id_ex_alu_op      (id_ex_alu_op),
        .id_ex_alu_src     (id_ex_alu_src),
        .id_ex_reg_write   (id_ex_reg_write),
        .id_ex_mem_read    (id_ex_mem_read),
        .id_ex_mem_write   (id_ex_mem_write),
        .id_ex_mem_to_reg  (id_ex_mem_to_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic idx_t mk(input logic [31:0] pc, input logic [31:0] rsd,
                                input logic [31:0] rtd, input logic [31:0] imm,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] dst, input logic [3:0] op,
                                input logic src, input logic rw, input logic mr,
                                input logic mw, input logic m2r);
        idx_t r;
        r = '{pc, rsd, rtd, imm, rs, rt, dst, op, src, rw, mr, mw, m2r};
        return r;
    endfunction

    function automatic vec_t v(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [3:0] comb, input idx_t idx);
        vec_t r;
        r.instr = instr;  r.pc = pc;
        r.wb_we = 1'b0;   r.wb_rd = '0;  r.wb_data = '0;
        r.em_we = 1'b0;   r.em_mr = 1'b0; r.em_rd = '0; r.em_res = '0;
        r.comb  = comb;   r.idx = idx;
        return r;
    endfunction

    function automatic idx_t act_idx();
        idx_t r;
        r = '{id_ex_pc_next, id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_rs, id_ex_rt,
              id_ex_dst, id_ex_alu_op, id_ex_alu_src, id_ex_reg_write, id_ex_mem_read,
              id_ex_mem_write, id_ex_mem_to_reg};
        return r;
    endfunction

    task automatic chk(input string name, input logic [151:0] act, input logic [151:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        if_id_instruction = t.instr;
        if_id_pc_next     = t.pc;
        wb_reg_write      = t.wb_we;
        wb_rd             = t.wb_rd;
        wb_data           = t.wb_data;
        ex_mem_reg_write  = t.em_we;
        ex_mem_mem_read   = t.em_mr;
        ex_mem_rd         = t.em_rd;
        ex_mem_alu_result = t.em_res;
    endtask

    // Drive one IF/ID slot, check the combinational side mid-cycle, then the
    // registered bundle after the edge via the scoreboard.
    task automatic apply(input vec_t t, input int i);
        logic [31:0] exp_br, exp_j;
        idx_t        e;
        drive(t);
        #2;
        exp_br = t.pc + {{14{t.instr[15]}}, t.instr[15:0], 2'b00};
        exp_j  = {t.pc[31:28], t.instr[25:0], 2'b00};
        chk($sformatf("v%0d ctrl", i), {stall, flush_if, jump_taken, branch_taken}, t.comb);
        chk($sformatf("v%0d pc_branch", i), pc_branch, exp_br);
        chk($sformatf("v%0d pc_jump", i), pc_jump, exp_j);
        sb_q.push_back(t.idx);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk($sformatf("v%0d id_ex", i), act_idx(), e);
    endtask

    initial begin
        vec_t t;

        // instruction, pc_next, {stall,flush,jump,branch}, expected ID/EX
        tbl[0]  = v(32'h0000_0000, 32'h100, 4'b0000, '0);
        tbl[0].wb_we = 1'b1; tbl[0].wb_rd = 5'd1; tbl[0].wb_data = 32'd5;
        // add r3,r1,r2 with r2=7 written back the same cycle
        tbl[1]  = v(32'h0022_1820, 32'h104, 4'b0000,
                    mk(32'h104, 32'd5, 32'd7, 32'h1820, 5'd1, 5'd2, 5'd3, 4'(AluAdd),
                       1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[1].wb_we = 1'b1; tbl[1].wb_rd = 5'd2; tbl[1].wb_data = 32'd7;
        // lw r4,0(r0)
        tbl[2]  = v(32'h8C04_0000, 32'h108, 4'b0000,
                    mk(32'h108, 32'd0, 32'd0, 32'd0, 5'd0, 5'd4, 5'd4, 4'(AluAdd),
                       1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
        // add r5,r4,r4 : load-use stall, then issues with r4=9 from WB
        tbl[3]  = v(32'h0084_2820, 32'h10C, 4'b1000, '0);
        tbl[4]  = v(32'h0084_2820, 32'h10C, 4'b0000,
                    mk(32'h10C, 32'd9, 32'd9, 32'h2820, 5'd4, 5'd4, 5'd5, 4'(AluAdd),
                       1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[4].wb_we = 1'b1; tbl[4].wb_rd = 5'd4; tbl[4].wb_data = 32'd9;
        // beq r1,r1,+3 at 0x10 with r1 forwarded -> taken to 0x1C
        tbl[5]  = v(32'h1021_0003, 32'h10, 4'b0101, '0);
        tbl[5].em_we = 1'b1; tbl[5].em_rd = 5'd1; tbl[5].em_res = 32'h1234;
        // beq r1,r2,-2 : r1 forwarded as 7 equals r2 -> taken backwards
        tbl[6]  = v(32'h1022_FFFE, 32'h200, 4'b0101, '0);
        tbl[6].em_we = 1'b1; tbl[6].em_rd = 5'd1; tbl[6].em_res = 32'd7;
        // bne r6,r0 with r6=0 -> not taken, issues as a no-write bundle
        tbl[7]  = v(32'h14C0_0001, 32'h204, 4'b0000,
                    mk(32'h204, 32'd0, 32'd0, 32'd1, 5'd6, 5'd0, 5'd0, 4'd0,
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        // add r7,r1,r0
        tbl[8]  = v(32'h0020_3820, 32'h208, 4'b0000,
                    mk(32'h208, 32'd5, 32'd0, 32'h3820, 5'd1, 5'd0, 5'd7, 4'(AluAdd),
                       1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        // beq r7,r1,+2 : r7 in EX -> stall, then resolves with r7 forwarded as 5
        tbl[9]  = v(32'h10E1_0002, 32'h20C, 4'b1000, '0);
        tbl[10] = v(32'h10E1_0002, 32'h20C, 4'b0101, '0);
        tbl[10].em_we = 1'b1; tbl[10].em_rd = 5'd7; tbl[10].em_res = 32'd5;
        // j 0x40 at 0x30000004 -> 0x30000100
        tbl[11] = v(32'h0800_0040, 32'h3000_0004, 4'b0110, '0);
        // write r0 then read it while writing it again
        tbl[12] = v(32'h0000_0000, 32'h210, 4'b0000, '0);
        tbl[12].wb_we = 1'b1; tbl[12].wb_rd = 5'd0; tbl[12].wb_data = 32'hDEAD;
        tbl[13] = v(32'h2008_FFFF, 32'h214, 4'b0000,
                    mk(32'h214, 32'd0, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd8, 5'd8, 4'(AluAdd),
                       1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[13].wb_we = 1'b1; tbl[13].wb_rd = 5'd0; tbl[13].wb_data = 32'hBEEF;
        // ori r9,r0,0x8001 (zero-extend)
        tbl[14] = v(32'h3409_8001, 32'h218, 4'b0000,
                    mk(32'h218, 32'd0, 32'd0, 32'h0000_8001, 5'd0, 5'd9, 5'd9, 4'(AluOr),
                       1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        // lui r10,0x1234
        tbl[15] = v(32'h3C0A_1234, 32'h21C, 4'b0000,
                    mk(32'h21C, 32'd0, 32'd0, 32'h1234_0000, 5'd0, 5'd10, 5'd10,
                       4'(AluLui), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        // beq r1,r2 while a load to r2 sits in MEM -> stall
        tbl[16] = v(32'h1022_0001, 32'h220, 4'b1000, '0);
        tbl[16].em_mr = 1'b1; tbl[16].em_rd = 5'd2;
        // sw r2,4(r1)
        tbl[17] = v(32'hAC22_0004, 32'h224, 4'b0000,
                    mk(32'h224, 32'd5, 32'd7, 32'd4, 5'd1, 5'd2, 5'd2, 4'(AluAdd),
                       1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        // slt r12,r1,r2
        tbl[18] = v(32'h0022_602A, 32'h228, 4'b0000,
                    mk(32'h228, 32'd5, 32'd7, 32'h602A, 5'd1, 5'd2, 5'd12, 4'(AluSlt),
                       1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        // unsupported opcode 0x3F -> bubble
        tbl[19] = v(32'hFC00_0000, 32'h22C, 4'b0000, '0);

        // Reset
        rst = 1'b1;
        drive(v(32'h0, 32'h0, 4'b0000, '0));
        #12;
        chk("reset id_ex", act_idx(), '0);
        chk("reset ctrl", {stall, flush_if}, 2'b00);
`ifdef ID_STALL_CNT_EN
        chk("reset counters", {stall_cycles, redirect_count}, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVec; i++) begin
            apply(tbl[i], i);
        end

`ifdef ID_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, 32'd3);
        chk("redirect_count", redirect_count, 32'd4);
`endif

        // andi r13,r2,0xFFFF : zero-extended immediate
        apply(v(32'h304D_FFFF, 32'h230, 4'b0000,
                mk(32'h230, 32'd7, 32'd0, 32'h0000_FFFF, 5'd2, 5'd13, 5'd13, 4'(AluAnd),
                   1'b1, 1'b1, 1'b0, 1'b0, 1'b0)), 20);

        // Reset asserted in the middle of a load-use stall
        drive(v(32'h8C04_0000, 32'h300, 4'b0000, '0));
        @(posedge clk);
        #1;
        drive(v(32'h0084_2820, 32'h304, 4'b0000, '0));
        #2;
        chk("midrst pre stall", stall, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst id_ex", act_idx(), '0);
        chk("midrst ctrl", {stall, flush_if}, 2'b00);
`ifdef ID_STALL_CNT_EN
        chk("midrst counters", {stall_cycles, redirect_count}, 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Register file was cleared: add r3,r1,r2 now reads zeros
        t = v(32'h0022_1820, 32'h308, 4'b0000,
              mk(32'h308, 32'd0, 32'd0, 32'h1820, 5'd1, 5'd2, 5'd3, 4'(AluAdd),
                 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        apply(t, 21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
